// File: rtl/distance_ranger.sv
// -----------------------------------------------------------------------------
// distance_ranger
//   Ultrasonic ranging sequencer on an Avalon-MM slave. Fires the trigger
//   pulse, times the echo high period, stores the result and raises a level
//   IRQ, so the CPU only reads back finished measurements.
//
// Ports
//   csi_clk, rsi_reset_n      clock, asynchronous active-low reset
//   avs_s0_write/read         Avalon strobes
//   avs_s0_address[2:0]       register select
//   avs_s0_writedata[31:0]    write data
//   avs_s0_readdata[31:0]     registered read data (0 when not reading)
//   avm_s0_irq                level IRQ = done & irq_en
//   trig_out                  sensor trigger
//   echo_in                   sensor echo (asynchronous)
//
// Register map
//   0 CTRL    W: b0 start (pulse), b1 continuous, b2 irq_en, b3 min/max reset
//             R: {b2,b1}
//   1 STATUS  R: b0 busy, b1 done, b2 timeout   W: b1=1 clears done+timeout
//   2 RESULT  echo high time in cycles
//   3 COUNT   completed measurements (16 bit, wraps)
//   4 MIN / 5 MAX  only with DISTANCE_MINMAX_EN defined, else read 0
// -----------------------------------------------------------------------------
module distance_ranger #(
    parameter int unsigned TRIG_CYCLES    = 500,
    parameter int unsigned TIMEOUT_CYCLES = 1250000,
    parameter int unsigned HOLDOFF_CYCLES = 3000000,
    parameter int unsigned CNT_W          = 24
) (
    input  logic        csi_clk,
    input  logic        rsi_reset_n,
    input  logic        avs_s0_write,
    input  logic        avs_s0_read,
    input  logic [2:0]  avs_s0_address,
    input  logic [31:0] avs_s0_writedata,
    output logic [31:0] avs_s0_readdata,
    output logic        avm_s0_irq,
    output logic        trig_out,
    input  logic        echo_in
);

    // One shared phase timer covers TRIG, the timeout window and HOLDOFF.
    localparam int unsigned TMR_MAX =
        (HOLDOFF_CYCLES > TIMEOUT_CYCLES)
            ? ((HOLDOFF_CYCLES > TRIG_CYCLES) ? HOLDOFF_CYCLES : TRIG_CYCLES)
            : ((TIMEOUT_CYCLES > TRIG_CYCLES) ? TIMEOUT_CYCLES : TRIG_CYCLES);
    localparam int unsigned TMR_W = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] TRIG_LAST = TMR_W'(TRIG_CYCLES - 1);
    localparam logic [TMR_W-1:0] TO_LAST   = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] HO_LAST   = TMR_W'(HOLDOFF_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_TRIG, S_WAIT_RISE, S_MEASURE, S_DONE_WR, S_HOLDOFF
    } state_e;

    state_e             state_q, state_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [CNT_W-1:0]   echo_cnt_q, echo_cnt_d;
    logic               echo_meta_q, echo_sync_q, echo_prev_q;
    logic               echo_rise, echo_fall;
    logic               cont_q, irq_en_q, done_q, timeout_q;
    logic [CNT_W-1:0]   result_q;
    logic [15:0]        count_q;
    logic [31:0]        rdata_d, rdata_q;
    logic               commit, commit_timeout;
    logic [CNT_W-1:0]   commit_value;
    logic               wr_ctrl, start_req, clear_req, busy;

    // ---------------------------------------------------------------- bus decode
    assign wr_ctrl   = avs_s0_write && (avs_s0_address == 3'd0);
    assign start_req = wr_ctrl && avs_s0_writedata[0];
    assign clear_req = avs_s0_write && (avs_s0_address == 3'd1) && avs_s0_writedata[1];
    assign busy      = (state_q != S_IDLE);

    // ---------------------------------------------------------- echo synchroniser
    // echo_prev_q follows the synchronised level in every state, so an echo
    // already high when WAIT_RISE is entered never looks like a rise.
    always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
        if (!rsi_reset_n) begin
            echo_meta_q <= 1'b0;
            echo_sync_q <= 1'b0;
            echo_prev_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the old
            // value of its neighbour, which is what builds the 2-FF chain.
            echo_meta_q <= echo_in;
            echo_sync_q <= echo_meta_q;
            echo_prev_q <= echo_sync_q;
        end
    end

    assign echo_rise = echo_sync_q & ~echo_prev_q;
    assign echo_fall = ~echo_sync_q & echo_prev_q;

    // ----------------------------------------------------------------------- FSM
    always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
        if (!rsi_reset_n) begin
            state_q    <= S_IDLE;
            tmr_q      <= '0;
            echo_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            echo_cnt_q <= echo_cnt_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d        = state_q;
        tmr_d          = tmr_q;
        echo_cnt_d     = echo_cnt_q;
        commit         = 1'b0;
        commit_timeout = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start_req || cont_q) begin
                    state_d = S_TRIG;
                    tmr_d   = '0;
                end
            end
            S_TRIG: begin
                if (tmr_q == TRIG_LAST) begin
                    state_d = S_WAIT_RISE;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            S_WAIT_RISE: begin
                if (tmr_q == TO_LAST) begin
                    commit         = 1'b1;
                    commit_timeout = 1'b1;
                    state_d        = S_HOLDOFF;
                    tmr_d          = '0;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                    if (echo_rise) begin
                        // The rise cycle itself already has echo high.
                        state_d    = S_MEASURE;
                        echo_cnt_d = CNT_W'(1);
                    end
                end
            end
            S_MEASURE: begin
                if (echo_fall) begin
                    state_d = S_DONE_WR;
                end else if (tmr_q == TO_LAST) begin
                    commit         = 1'b1;
                    commit_timeout = 1'b1;
                    state_d        = S_HOLDOFF;
                    tmr_d          = '0;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                    if (echo_sync_q && (echo_cnt_q != '1)) begin
                        echo_cnt_d = echo_cnt_q + CNT_W'(1);
                    end
                end
            end
            S_DONE_WR: begin
                commit  = 1'b1;
                state_d = S_HOLDOFF;
                tmr_d   = '0;
            end
            S_HOLDOFF: begin
                if (tmr_q == HO_LAST) begin
                    tmr_d   = '0;
                    state_d = cont_q ? S_TRIG : S_IDLE;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign commit_value = commit_timeout ? CNT_W'(TIMEOUT_CYCLES) : echo_cnt_q;

    // ------------------------------------------------------------ control / status
    always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
        if (!rsi_reset_n) begin
            cont_q    <= 1'b0;
            irq_en_q  <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            result_q  <= '0;
            count_q   <= '0;
        end else begin
            if (wr_ctrl) begin
                cont_q   <= avs_s0_writedata[1];
                irq_en_q <= avs_s0_writedata[2];
            end
            // A new result takes priority over a simultaneous clear.
            if (commit) begin
                done_q    <= 1'b1;
                timeout_q <= commit_timeout;
                result_q  <= commit_value;
                count_q   <= count_q + 16'd1;
            end else if (clear_req) begin
                done_q    <= 1'b0;
                timeout_q <= 1'b0;
            end
        end
    end

`ifdef DISTANCE_MINMAX_EN
    logic [CNT_W-1:0] min_q, max_q, min_base, max_base;
    logic             minmax_clr;
    logic             unused_wdata;

    assign minmax_clr   = wr_ctrl && avs_s0_writedata[3];
    assign unused_wdata = ^avs_s0_writedata[31:4];

    // Clearing first and then folding in a same-cycle result makes the
    // result win: min(all-ones, r) = r and max(0, r) = r.
    always_comb begin
        min_base = minmax_clr ? '1 : min_q;
        max_base = minmax_clr ? '0 : max_q;
    end

    always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
        if (!rsi_reset_n) begin
            min_q <= '1;
            max_q <= '0;
        end else if (commit && !commit_timeout) begin
            min_q <= (commit_value < min_base) ? commit_value : min_base;
            max_q <= (commit_value > max_base) ? commit_value : max_base;
        end else begin
            min_q <= min_base;
            max_q <= max_base;
        end
    end
`else
    logic unused_wdata;
    assign unused_wdata = ^avs_s0_writedata[31:3];
`endif

    // ------------------------------------------------------------------ readback
    always_comb begin
        rdata_d = '0;
        if (avs_s0_read) begin
            case (avs_s0_address)
                3'd0: rdata_d = {29'd0, irq_en_q, cont_q, 1'b0};
                3'd1: rdata_d = {29'd0, timeout_q, done_q, busy};
                3'd2: rdata_d = 32'(result_q);
                3'd3: rdata_d = 32'(count_q);
`ifdef DISTANCE_MINMAX_EN
                3'd4: rdata_d = 32'(min_q);
                3'd5: rdata_d = 32'(max_q);
`endif
                default: rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
        if (!rsi_reset_n) rdata_q <= '0;
        else              rdata_q <= rdata_d;
    end

    assign avs_s0_readdata = rdata_q;
    assign avm_s0_irq      = done_q & irq_en_q;
    assign trig_out        = (state_q == S_TRIG);

endmodule

// File: tb/tb_distance_ranger.sv
// -----------------------------------------------------------------------------
// tb_distance_ranger
//   Bench for distance_ranger with short timing parameters. A sensor model
//   answers each trigger with a queued echo shape; the expected RESULT of each
//   shape is pushed to a scoreboard queue and compared when the measurement
//   completes.
// -----------------------------------------------------------------------------
module tb_distance_ranger;

    localparam int TRIG    = 4;
    localparam int TIMEOUT = 100;
    localparam int HOLDOFF = 20;

    logic        clk;
    logic        rst_n;
    logic        wr, rd;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;
    logic        trig_out;
    logic        echo_in;

    distance_ranger #(
        .TRIG_CYCLES    (TRIG),
        .TIMEOUT_CYCLES (TIMEOUT),
        .HOLDOFF_CYCLES (HOLDOFF),
        .CNT_W          (24)
    ) dut (
        .csi_clk          (clk),
        .rsi_reset_n      (rst_n),
        .avs_s0_write     (wr),
        .avs_s0_read      (rd),
        .avs_s0_address   (addr),
        .avs_s0_writedata (wdata),
        .avs_s0_readdata  (rdata),
        .avm_s0_irq       (irq),
        .trig_out         (trig_out),
        .echo_in          (echo_in)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ------------------------------------------------------------- bookkeeping
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        int pre;    // cycles echo stays high after trigger fall (0 = starts low)
        int gap;    // low cycles before the echo pulse
        int width;  // echo pulse length in cycles (0 = never rises)
    } echo_spec_t;

    echo_spec_t  spec_q[$];
    logic [31:0] exp_q[$];
    int          rise_q[$];
    int          trig_cnt      = 0;
    int          last_trig_len = 0;
    int          trig_fall_cyc = 0;

    // ------------------------------------------------------------ sensor model
    task automatic play_echo(input echo_spec_t sp);
        repeat (sp.pre) @(negedge clk);
        echo_in = 1'b0;
        if (sp.width > 0) begin
            repeat (sp.gap) @(negedge clk);
            echo_in = 1'b1;
            repeat (sp.width) @(negedge clk);
            echo_in = 1'b0;
        end
    endtask

    initial begin
        echo_spec_t sp;
        bit         have;
        int         len;
        echo_in = 1'b0;
        forever begin
            @(negedge clk);
            if (trig_out) begin
                trig_cnt++;
                rise_q.push_back(cyc);
                have = (spec_q.size() > 0);
                if (have) begin
                    sp = spec_q.pop_front();
                    if (sp.pre > 0) echo_in = 1'b1;
                end
                len = 0;
                while (trig_out) begin
                    len++;
                    @(negedge clk);
                end
                last_trig_len = len;
                trig_fall_cyc = cyc;
                if (have) play_echo(sp);
            end
        end
    end

    // --------------------------------------------------------------- bus tasks
    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        wr = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        wr = 1'b0; wdata = '0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        rd = 1'b1; addr = a;
        @(negedge clk);
        d  = rdata;
        rd = 1'b0;
    endtask

    task automatic wait_irq(output int at);
        int n = 0;
        while (!irq && n < 400) begin
            @(negedge clk);
            n++;
        end
        at = cyc;
        check("wait_irq", 32'(irq), 32'd1);
    endtask

    task automatic wait_idle(output int at);
        logic [31:0] v;
        int n = 0;
        bus_read(3'd1, v);
        while (v[0] && n < 200) begin
            bus_read(3'd1, v);
            n++;
        end
        at = cyc;
        check("wait_idle", 32'(v[0]), 32'd0);
    endtask

    task automatic wait_count(input int target);
        logic [31:0] v;
        int n = 0;
        bus_read(3'd3, v);
        while (v != 32'(target) && n < 300) begin
            bus_read(3'd3, v);
            n++;
        end
        check("wait_count", v, 32'(target));
    endtask

    task automatic compare_result();
        logic [31:0] v;
        bus_read(3'd2, v);
        if (exp_q.size() == 0) check("sb_underflow", 32'(exp_q.size()), 32'd1);
        else                   check("result", v, exp_q.pop_front());
    endtask

    task automatic expect_echo(input int pre, input int gap, input int width, input int res);
        echo_spec_t sp;
        sp.pre = pre; sp.gap = gap; sp.width = width;
        spec_q.push_back(sp);
        exp_q.push_back(32'(res));
    endtask

    // ------------------------------------------------------------------ watchdog
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    // --------------------------------------------------------------- main flow
    initial begin
        logic [31:0] v;
        int t0, t_done, t_idle, exp_count;

        rst_n = 1'b0; wr = 1'b0; rd = 1'b0; addr = '0; wdata = '0;
        exp_count = 0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_trig", 32'(trig_out), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        rst_n = 1'b1;
        bus_read(3'd0, v); check("rst_ctrl", v, 32'd0);
        bus_read(3'd1, v); check("rst_status", v, 32'd0);
        bus_read(3'd3, v); check("rst_count", v, 32'd0);
        bus_read(3'd7, v); check("unmapped", v, 32'd0);

        // Single shot, 37-cycle echo, IRQ enabled
        expect_echo(0, 10, 37, 37);
        bus_write(3'd0, 32'h5);
        wait_irq(t_done);
        exp_count++;
        check("trig_len", 32'(last_trig_len), 32'(TRIG));
        wait_idle(t_idle);
        compare_result();
        bus_read(3'd1, v); check("status_done", v, 32'h2);
        check("irq_set", 32'(irq), 32'd1);
        bus_read(3'd3, v); check("count1", v, 32'(exp_count));
        bus_read(3'd0, v); check("ctrl_rd", v, 32'h4);

        // Clear done; start while busy must be ignored
        bus_write(3'd1, 32'h2);
        @(negedge clk);
        check("irq_clr", 32'(irq), 32'd0);
        bus_read(3'd1, v); check("status_clr", v, 32'h0);
        expect_echo(0, 10, 20, 20);
        t0 = trig_cnt;
        bus_write(3'd0, 32'h5);
        for (int n = 0; n < 20 && trig_cnt == t0; n++) @(negedge clk);
        check("trig_seen", 32'(trig_cnt), 32'(t0 + 1));
        repeat (8) @(negedge clk);
        bus_write(3'd0, 32'h5);
        wait_irq(t_done);
        exp_count++;
        wait_idle(t_idle);
        compare_result();
        check("busy_start_trig", 32'(trig_cnt), 32'(t0 + 1));
        bus_read(3'd3, v); check("busy_start_count", v, 32'(exp_count));

        // Timeout: echo never rises
        bus_write(3'd1, 32'h2);
        expect_echo(0, 0, 0, TIMEOUT);
        bus_write(3'd0, 32'h5);
        wait_irq(t_done);
        exp_count++;
        check("timeout_latency", 32'(t_done - trig_fall_cyc), 32'(TIMEOUT));
        repeat (8) @(negedge clk);
        bus_read(3'd1, v); check("status_holdoff", v, 32'h7);
        wait_idle(t_idle);
        check("holdoff_len", 32'((t_idle - t_done) >= HOLDOFF && (t_idle - t_done) <= HOLDOFF + 3), 32'd1);
        bus_read(3'd1, v); check("status_timeout", v, 32'h6);
        compare_result();

        // Echo already high at trigger fall: only the later pulse counts
        bus_write(3'd1, 32'h2);
        expect_echo(3, 5, 8, 8);
        bus_write(3'd0, 32'h5);
        wait_irq(t_done);
        exp_count++;
        wait_idle(t_idle);
        compare_result();
        bus_read(3'd1, v); check("status_pre", v, 32'h2);

        // Continuous mode, three echoes; continuous cleared during the third
        bus_write(3'd0, 32'h8);
        bus_write(3'd1, 32'h2);
        expect_echo(0, 10, 10, 10);
        expect_echo(0, 10, 50, 50);
        expect_echo(0, 10, 30, 30);
        t0 = trig_cnt;
        rise_q.delete();
        bus_write(3'd0, 32'h2);
        for (int k = 0; k < 3; k++) begin
            exp_count++;
            wait_count(exp_count);
            compare_result();
            if (k == 1) begin
                for (int n = 0; n < 100 && trig_cnt < t0 + 3; n++) @(negedge clk);
                bus_write(3'd0, 32'h0);
            end
        end
        wait_idle(t_idle);
        repeat (HOLDOFF + 10) @(negedge clk);
        check("cont_trigs", 32'(trig_cnt), 32'(t0 + 3));
        bus_read(3'd3, v); check("cont_count", v, 32'(exp_count));
        bus_read(3'd2, v); check("cont_result", v, 32'd30);
        for (int i = 1; i < rise_q.size(); i++)
            check("trig_spacing", 32'((rise_q[i] - rise_q[i-1]) >= HOLDOFF + TRIG), 32'd1);
`ifdef DISTANCE_MINMAX_EN
        bus_read(3'd4, v); check("min", v, 32'd10);
        bus_read(3'd5, v); check("max", v, 32'd50);
`else
        bus_read(3'd4, v); check("min_absent", v, 32'd0);
        bus_read(3'd5, v); check("max_absent", v, 32'd0);
`endif

        // Reset in the middle of TRIG
        bus_write(3'd0, 32'h4);
        @(negedge clk);
        check("irq_pre_reset", 32'(irq), 32'd1);
        bus_write(3'd0, 32'h5);
        rd = 1'b1; addr = 3'd2;
        for (int n = 0; n < 10 && !trig_out; n++) @(negedge clk);
        @(negedge clk);
        check("midtrig_trig", 32'(trig_out), 32'd1);
        check("midtrig_rdata", rdata, 32'd30);
        rst_n = 1'b0;
        #1;
        check("rst_trig_now", 32'(trig_out), 32'd0);
        check("rst_irq_now", 32'(irq), 32'd0);
        check("rst_rdata_now", rdata, 32'd0);
        @(negedge clk);
        rd = 1'b0;
        rst_n = 1'b1;
        bus_read(3'd0, v); check("post_rst_ctrl", v, 32'd0);
        bus_read(3'd1, v); check("post_rst_status", v, 32'd0);
        bus_read(3'd2, v); check("post_rst_result", v, 32'd0);
        bus_read(3'd3, v); check("post_rst_count", v, 32'd0);

        // Reset in the middle of MEASURE
        spec_q.push_back('{pre: 0, gap: 3, width: 40});
        bus_write(3'd0, 32'h1);
        rd = 1'b1; addr = 3'd1;
        for (int n = 0; n < 40 && !echo_in; n++) @(negedge clk);
        repeat (10) @(negedge clk);
        check("midmeas_busy", rdata, 32'h1);
        rst_n = 1'b0;
        #1;
        check("rst2_trig_now", 32'(trig_out), 32'd0);
        check("rst2_irq_now", 32'(irq), 32'd0);
        check("rst2_rdata_now", rdata, 32'd0);
        @(negedge clk);
        rd = 1'b0;
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        bus_read(3'd1, v); check("post_rst2_status", v, 32'd0);
        bus_read(3'd2, v); check("post_rst2_result", v, 32'd0);
        bus_read(3'd3, v); check("post_rst2_count", v, 32'd0);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
